// File: rtl/seq_scan_pkg.sv
// ---------------------------------------------------------------------------
// seq_scan_pkg : shared state encoding and default sizes for the scan controller
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_scan_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TMO_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_window.sv
// ---------------------------------------------------------------------------
// seq_window : serial shift window with fill tracking and length-masked compare
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_window
    import seq_scan_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    output logic               match_next
);

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] window_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;

    always_comb begin
        window_next = window;
        fill_next   = fill;
        if (shift_en) begin
            window_next = {window[MAX_LEN-2:0], bit_in};
            if (fill < length) begin
                fill_next = fill + LEN_W'(1);
            end
        end
        // Only the newest 'length' bits take part in the compare
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < length);
        end
        match_next = shift_en && (fill_next >= length)
                     && (((window_next ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
            fill   <= '0;
        end else if (clear) begin
            window <= '0;
            fill   <= '0;
        end else begin
            window <= window_next;
            fill   <= fill_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_scan_controller.sv
// ---------------------------------------------------------------------------
// seq_scan_controller : programmable serial-pattern scan with target/timeout end
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_scan_controller
    import seq_scan_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TMO_W   = DEF_TMO_W
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_length,
    input  logic [CNT_W-1:0]   i_target,
    input  logic [TMO_W-1:0]   i_timeout,
    input  logic               i_data_valid,
    input  logic               i_data_in,
    output logic               o_busy,
    output logic               o_match,
    output logic [CNT_W-1:0]   o_match_count,
    output logic               o_done,
    output logic               o_timeout,
    output logic               o_err,
    output logic [1:0]         o_state
);

    state_t             state;
    state_t             state_next;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   length;
    logic [CNT_W-1:0]   target;
    logic [TMO_W-1:0]   timeout;
    logic [CNT_W-1:0]   match_count;
    logic [TMO_W-1:0]   bit_count;
    logic               match_pulse;
    logic               err_pulse;
    logic               timeout_flag;

    logic               length_ok;
    logic               start_ok;
    logic               shift_en;
    logic               scan_bit;
    logic               win_match;
    logic               hit;
    logic [CNT_W-1:0]   count_next;
    logic [TMO_W-1:0]   bit_count_next;
    logic               target_hit;
    logic               timeout_hit;

    seq_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk        (i_clock),
        .rst        (i_reset),
        .clear      (state == ST_ARM),
        .shift_en   (shift_en),
        .bit_in     (i_data_in),
        .pattern    (pattern),
        .length     (length),
        .match_next (win_match)
    );

    always_comb begin
        length_ok      = (i_length != '0) && (32'(i_length) <= MAX_LEN);
        start_ok       = (state == ST_IDLE) && i_start && length_ok;
        shift_en       = (state == ST_SCAN) && i_data_valid;
        // An abort on the same bit discards any match it would have produced
        scan_bit       = shift_en && !i_abort;
        hit            = scan_bit && win_match;
        count_next     = (hit && (match_count != '1)) ? match_count + CNT_W'(1) : match_count;
        bit_count_next = scan_bit ? bit_count + TMO_W'(1) : bit_count;
        target_hit     = hit && (target != '0) && (count_next == target);
        timeout_hit    = scan_bit && !target_hit && (timeout != '0)
                         && (bit_count_next == timeout);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_ok) state_next = ST_ARM;
            ST_ARM:  state_next = i_abort ? ST_IDLE : ST_SCAN;
            ST_SCAN: begin
                if (i_abort) begin
                    state_next = ST_IDLE;
                end else if (target_hit || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            pattern      <= '0;
            length       <= '0;
            target       <= '0;
            timeout      <= '0;
            match_count  <= '0;
            bit_count    <= '0;
            match_pulse  <= 1'b0;
            err_pulse    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state       <= state_next;
            match_pulse <= hit;
            err_pulse   <= (state == ST_IDLE) && i_start && !length_ok;
            if (start_ok) begin
                pattern      <= i_pattern;
                length       <= i_length;
                target       <= i_target;
                timeout      <= i_timeout;
                match_count  <= '0;
                timeout_flag <= 1'b0;
            end
            if (state == ST_ARM) begin
                bit_count <= '0;
            end
            if (scan_bit) begin
                match_count <= count_next;
                bit_count   <= bit_count_next;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign o_busy        = (state == ST_ARM) || (state == ST_SCAN);
    assign o_done        = (state == ST_DONE);
    assign o_match       = match_pulse;
    assign o_match_count = match_count;
    assign o_timeout     = timeout_flag;
    assign o_err         = err_pulse;
    assign o_state       = state;

endmodule

`default_nettype wire

// File: tb/tb_seq_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seq_scan_controller : directed scoreboard bench for seq_scan_controller
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_scan_controller;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 8;
    localparam int TMO_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   length;
    logic [CNT_W-1:0]   target;
    logic [TMO_W-1:0]   timeout;
    logic               data_valid;
    logic               data_in;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               tmo;
    logic               err;
    logic [1:0]         state;

    always #5 clk = ~clk;

    seq_scan_controller #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W),
        .TMO_W   (TMO_W)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_pattern     (pattern),
        .i_length      (length),
        .i_target      (target),
        .i_timeout     (timeout),
        .i_data_valid  (data_valid),
        .i_data_in     (data_in),
        .o_busy        (busy),
        .o_match       (match),
        .o_match_count (match_count),
        .o_done        (done),
        .o_timeout     (tmo),
        .o_err         (err),
        .o_state       (state)
    );

    typedef struct {
        logic [1:0]       st;
        logic             busy;
        logic             match;
        logic             done;
        logic             tmo;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: full bit history compared against the pattern
    bit         hist[$];
    logic [7:0] m_pat;
    int         m_len;
    int         m_tgt;
    int         m_tmo;
    int         m_bits;
    logic [7:0] m_cnt   = '0;
    logic       m_tflag = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("match", 32'(match), 32'(e.match));
        chk("done", 32'(done), 32'(e.done));
        chk("timeout", 32'(tmo), 32'(e.tmo));
        chk("err", 32'(err), 32'(e.err));
        chk("count", 32'(match_count), 32'(e.cnt));
    endtask

    task automatic push_idle(input logic e_err);
        exp_t e;
        e.st = 2'd0; e.busy = 1'b0; e.match = 1'b0; e.done = 1'b0;
        e.tmo = m_tflag; e.err = e_err; e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic idle_cycle();
        start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        push_idle(1'b0);
        tick();
    endtask

    task automatic bad_start(input logic [LEN_W-1:0] len);
        start = 1'b1; abort = 1'b0; data_valid = 1'b0;
        length = len; pattern = 8'hFF; target = 8'd1; timeout = 16'd0;
        push_idle(1'b1);
        tick();
        idle_cycle();
    endtask

    task automatic start_scan(input logic [7:0] pat, input int len, input int tgt, input int tmo_v);
        exp_t e;
        start = 1'b1; abort = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        pattern = pat; length = LEN_W'(len); target = CNT_W'(tgt); timeout = TMO_W'(tmo_v);
        m_pat = pat; m_len = len; m_tgt = tgt; m_tmo = tmo_v;
        m_bits = 0; m_cnt = '0; m_tflag = 1'b0; hist.delete();
        e.st = 2'd1; e.busy = 1'b1; e.match = 1'b0; e.done = 1'b0;
        e.tmo = 1'b0; e.err = 1'b0; e.cnt = '0;
        sb.push_back(e);
        tick();
        // ARM cycle: a valid bit here must be dropped; config inputs are scrambled
        start = 1'b0; data_valid = 1'b1; data_in = 1'b1;
        pattern = ~pat; length = LEN_W'(len + 1); target = '0; timeout = '0;
        e.st = 2'd2;
        sb.push_back(e);
        tick();
    endtask

    task automatic scan_bit(input bit v, input bit b, input bit ab);
        exp_t e;
        bit   hit = 1'b0;
        bit   fin = 1'b0;
        start = 1'b0; data_valid = v; data_in = b; abort = ab;
        if (ab) begin
            e.st = 2'd0; e.busy = 1'b0; e.match = 1'b0; e.done = 1'b0;
        end else begin
            if (v) begin
                hist.push_back(b);
                m_bits++;
                if (hist.size() >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++) begin
                        if (hist[hist.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                    end
                end
                if (hit && m_cnt != 8'hFF) m_cnt++;
                if (hit && m_tgt != 0 && int'(m_cnt) == m_tgt) begin
                    fin = 1'b1;
                end else if (m_tmo != 0 && m_bits == m_tmo) begin
                    fin = 1'b1;
                    m_tflag = 1'b1;
                end
            end
            e.st = fin ? 2'd3 : 2'd2; e.busy = !fin; e.match = hit; e.done = fin;
        end
        e.tmo = m_tflag; e.err = 1'b0; e.cnt = m_cnt;
        sb.push_back(e);
        tick();
    endtask

    task automatic scan_bits(input logic [15:0] bits_v, input int n);
        for (int i = n - 1; i >= 0; i--) scan_bit(1'b1, bits_v[i], 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        pattern = '0; length = '0; target = '0; timeout = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        #3 rst = 1'b0;
        idle_cycle();

        // Overlapping 101 matches, stop on second match
        start_scan(8'b101, 3, 2, 0);
        scan_bits(16'b10101, 5);
        idle_cycle();

        // Timeout after four valid bits without a match
        start_scan(8'b111, 3, 1, 4);
        scan_bits(16'b0110, 4);
        idle_cycle();

        // Valid gating, target and timeout on the same bit: target wins
        start_scan(8'b11, 2, 1, 2);
        scan_bit(1'b1, 1'b1, 1'b0);
        repeat (3) scan_bit(1'b0, 1'b1, 1'b0);
        scan_bit(1'b1, 1'b1, 1'b0);
        idle_cycle();

        // Illegal lengths are rejected without touching counts
        bad_start(4'd0);
        bad_start(4'd9);

        // Abort discards the pending match and holds the count
        start_scan(8'b1100, 4, 0, 0);
        scan_bits(16'b1100, 4);
        scan_bits(16'b110, 3);
        scan_bit(1'b1, 1'b0, 1'b1);
        idle_cycle();
        start_scan(8'b1100, 4, 0, 0);
        scan_bit(1'b0, 1'b0, 1'b1);
        idle_cycle();

        // Full-width and single-bit pattern lengths
        start_scan(8'hA5, 8, 1, 0);
        scan_bits(16'hFA5, 12);
        idle_cycle();
        start_scan(8'b1, 1, 3, 0);
        scan_bits(16'b1101, 4);
        idle_cycle();

        // Asynchronous reset between edges during SCAN
        start_scan(8'b101, 3, 0, 0);
        scan_bits(16'b101, 3);
        data_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        #2 rst = 1'b0;
        m_cnt = '0; m_tflag = 1'b0;
        idle_cycle();
        start_scan(8'b11, 2, 1, 0);
        scan_bits(16'b11, 2);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
